// File: rtl/video_timing_pkg.sv
// Timing constants, width_mode encoding and fetch geometry lookup
// for the MC6847X raster timing generator.
package video_timing_pkg;
  localparam int unsigned H_TOTAL   = 458;
  localparam int unsigned H_SYNC    = 29;
  localparam int unsigned V_TOTAL_N = 257;
  localparam int unsigned V_TOTAL_P = 310;
  localparam int unsigned V_SYNC    = 8;
  localparam int unsigned PORT_X    = 129;
  localparam int unsigned PORT_W    = 256;
  localparam int unsigned PORT_Y_N  = 63;
  localparam int unsigned PORT_Y_P  = 88;
  localparam int unsigned PORT_H    = 192;
  localparam int unsigned LEAD      = 8;
  localparam int unsigned CHAR_MAX  = 12;

  typedef enum logic [1:0] {
    WM_32B     = 2'b00,
    WM_16B     = 2'b01,
    WM_8B      = 2'b10,
    WM_32B_ALT = 2'b11
  } widthModeT;

  // Pixels per byte as a shift amount, plus bytes per line.
  typedef struct packed {
    logic [2:0] ppbLog2;
    logic [5:0] bpl;
  } fetchGeomT;

  function automatic fetchGeomT fetchGeom(input widthModeT mode);
    fetchGeomT g;
    case (mode)
      WM_16B:  g = '{ppbLog2: 3'd4, bpl: 6'd16};
      WM_8B:   g = '{ppbLog2: 3'd5, bpl: 6'd8};
      default: g = '{ppbLog2: 3'd3, bpl: 6'd32};
    endcase
    return g;
  endfunction
endpackage

// File: rtl/video_timing_wrap_counter.sv
// Modulo counter: counts 0..limit while enabled, wraps to 0; clear wins over enable.
module wrap_counter #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  assign wrap = enable && (count == limit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= wrap ? '0 : count + WIDTH'(1);
  end
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: col/row counters, per-frame config latch,
// fetch strobes and character-cell sequencing, all outputs registered.
module video_timing_gen #(
  parameter int unsigned H_TOTAL   = video_timing_pkg::H_TOTAL,
  parameter int unsigned H_SYNC    = video_timing_pkg::H_SYNC,
  parameter int unsigned V_TOTAL_N = video_timing_pkg::V_TOTAL_N,
  parameter int unsigned V_TOTAL_P = video_timing_pkg::V_TOTAL_P,
  parameter int unsigned V_SYNC    = video_timing_pkg::V_SYNC,
  parameter int unsigned PORT_X    = video_timing_pkg::PORT_X,
  parameter int unsigned PORT_W    = video_timing_pkg::PORT_W,
  parameter int unsigned PORT_Y_N  = video_timing_pkg::PORT_Y_N,
  parameter int unsigned PORT_Y_P  = video_timing_pkg::PORT_Y_P,
  parameter int unsigned PORT_H    = video_timing_pkg::PORT_H,
  parameter int unsigned LEAD      = video_timing_pkg::LEAD,
  parameter int unsigned CHAR_MAX  = video_timing_pkg::CHAR_MAX
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       format,
  input  logic [1:0] width_mode,
  input  logic [3:0] char_rows,
  output logic       hsn,
  output logic       fsn,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic       fetch,
  output logic [4:0] byte_idx,
  output logic       preload,
  output logic [3:0] cell_line,
  output logic       rowclear,
  output logic [4:0] cell_row,
  output logic       frame_sof,
  output logic [8:0] col,
  output logic [8:0] row
);
  import video_timing_pkg::*;

  localparam int unsigned FETCH_X = PORT_X - LEAD;

  logic [8:0] colCnt, rowCnt;
  logic       colWrap, rowWrap;
  logic       cfgValid;
  logic [8:0] vtotL, portYL, vtotNext, portYNext, vtotEff, portYEff;
  logic [3:0] heightL, heightNext, heightEff;
  widthModeT  wmL;

  // Until the first clock after reset the live inputs stand in for the latch.
  assign vtotNext   = format ? 9'(V_TOTAL_P) : 9'(V_TOTAL_N);
  assign portYNext  = format ? 9'(PORT_Y_P) : 9'(PORT_Y_N);
  assign heightNext = (char_rows == 4'd0) ? 4'(CHAR_MAX) : char_rows;
  assign vtotEff    = cfgValid ? vtotL : vtotNext;
  assign portYEff   = cfgValid ? portYL : portYNext;
  assign heightEff  = cfgValid ? heightL : heightNext;

  wrap_counter #(.WIDTH(9)) colCtr (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .enable(1'b1),
    .limit(9'(H_TOTAL - 1)), .count(colCnt), .wrap(colWrap)
  );

  wrap_counter #(.WIDTH(9)) rowCtr (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .enable(colWrap),
    .limit(vtotEff - 9'd1), .count(rowCnt), .wrap(rowWrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfgValid <= 1'b0;
      vtotL    <= 9'(V_TOTAL_N);
      portYL   <= 9'(PORT_Y_N);
      heightL  <= 4'(CHAR_MAX);
      wmL      <= WM_32B;
    end else begin
      cfgValid <= 1'b1;
      if (!cfgValid || rowWrap) begin
        vtotL   <= vtotNext;
        portYL  <= portYNext;
        heightL <= heightNext;
      end
      if (colCnt == '0) wmL <= widthModeT'(width_mode);
    end
  end

  logic [9:0] rowExt, portEnd, colExt;
  logic       rowActive, rowFirst, rowExit, colZero, colActive;
  logic       cellAdvance, cellClear, cellWrap;

  assign rowExt    = {1'b0, rowCnt};
  assign colExt    = {1'b0, colCnt};
  assign portEnd   = {1'b0, portYEff} + 10'(PORT_H);
  assign rowActive = (rowCnt >= portYEff) && (rowExt < portEnd);
  assign rowFirst  = (rowCnt == portYEff);
  assign rowExit   = (rowExt == portEnd);
  assign colZero   = (colCnt == '0);
  assign colActive = (colExt >= 10'(PORT_X)) && (colExt < 10'(PORT_X + PORT_W));

  // The row just below the viewport still advances (so a final wrap pulses
  // rowclear) but clears in the same edge, keeping the cell state at 0 outside.
  assign cellAdvance = colZero && ((rowActive && !rowFirst) || rowExit);
  assign cellClear   = colZero && (rowFirst || rowExit);

  wrap_counter #(.WIDTH(4)) cellCtr (
    .clk(clk), .reset_n(reset_n), .clear(cellClear), .enable(cellAdvance),
    .limit(heightEff - 4'd1), .count(cell_line), .wrap(cellWrap)
  );

  fetchGeomT  geom;
  logic [9:0] fetchOff, fetchIdx;
  logic       fetchHit;

  always_comb begin
    geom     = fetchGeom(wmL);
    fetchOff = colExt - 10'(FETCH_X);
    fetchIdx = fetchOff >> geom.ppbLog2;
    fetchHit = rowActive && (colExt >= 10'(FETCH_X))
            && ((fetchOff & ((10'd1 << geom.ppbLog2) - 10'd1)) == 10'd0)
            && (fetchIdx < {4'd0, geom.bpl});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsn       <= 1'b1;
      fsn       <= 1'b1;
      hblank    <= 1'b1;
      vblank    <= 1'b1;
      de        <= 1'b0;
      fetch     <= 1'b0;
      byte_idx  <= '0;
      preload   <= 1'b0;
      rowclear  <= 1'b0;
      cell_row  <= '0;
      frame_sof <= 1'b0;
      col       <= '0;
      row       <= '0;
    end else begin
      hsn       <= colCnt >= 9'(H_SYNC);
      fsn       <= rowCnt >= 9'(V_SYNC);
      hblank    <= !colActive;
      vblank    <= !rowActive;
      de        <= colActive && rowActive;
      fetch     <= fetchHit;
      byte_idx  <= fetchHit ? fetchIdx[4:0] : '0;
      preload   <= fetchHit && (fetchIdx == 10'd0);
      rowclear  <= cellWrap;
      frame_sof <= colZero && (rowCnt == '0);
      col       <= colCnt;
      row       <= rowCnt;
      if (cellClear)                             cell_row <= '0;
      else if (cellWrap && (cell_row != 5'd31)) cell_row <= cell_row + 5'd1;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a vertically shortened raster
// (full horizontal timing) so that several whole frames fit in the run.
module tb_video_timing_gen;
  localparam int HT    = 458;
  localparam int VT_N  = 44;
  localparam int VT_P  = 50;
  localparam int VSYNC = 3;
  localparam int PY_N  = 4;
  localparam int PY_P  = 8;
  localparam int PH    = 36;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       format;
  logic [1:0] width_mode;
  logic [3:0] char_rows;
  logic       hsn, fsn, hblank, vblank, de, fetch, preload, rowclear, frame_sof;
  logic [4:0] byte_idx, cell_row;
  logic [3:0] cell_line;
  logic [8:0] col, row;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .V_TOTAL_N(VT_N), .V_TOTAL_P(VT_P), .V_SYNC(VSYNC),
    .PORT_Y_N(PY_N), .PORT_Y_P(PY_P), .PORT_H(PH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .format(format), .width_mode(width_mode),
    .char_rows(char_rows), .hsn(hsn), .fsn(fsn), .hblank(hblank), .vblank(vblank),
    .de(de), .fetch(fetch), .byte_idx(byte_idx), .preload(preload),
    .cell_line(cell_line), .rowclear(rowclear), .cell_row(cell_row),
    .frame_sof(frame_sof), .col(col), .row(row)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One whole frame, sampled on falling edges; index i is the raster position
  // shown on the outputs. Mid-frame input changes must only affect later frames.
  task automatic runFrame(input string nm, input int vt, input int py, input int h,
                          input int ppb, input logic nf, input logic [3:0] nc,
                          input logic [1:0] nw, input int expFetch, input int expFirstFetch,
                          input int expFirstDe, input int expClr, input int expMaxRow);
    int syncBad = 0, blankBad = 0, posBad = 0, fetchBad = 0, cellBad = 0;
    int sofCnt = 0, hsnLow = 0, fsnLow = 0, deCnt = 0, fetchCnt = 0, clrCnt = 0;
    int firstFetch = -1, firstDe = -1, maxRow = 0;
    logic firstPre = 1'b0;
    for (int i = 0; i < vt * HT; i++) begin
      int c, r, a, off, k, clE, crE;
      logic inV, inH, fE, rcE;
      @(negedge clk);
      c   = i % HT;
      r   = i / HT;
      inV = (r >= py) && (r < py + PH);
      inH = (c >= 129) && (c < 385);
      off = c - 121;
      fE  = inV && (c >= 121) && (off % ppb == 0) && (off / ppb < 256 / ppb);
      k   = fE ? off / ppb : 0;
      a   = r - py;
      clE = inV ? a % h : 0;
      crE = inV ? ((a / h > 31) ? 31 : a / h) : 0;
      rcE = (c == 0) && (r >= py + 1) && (r <= py + PH) && ((r - py) % h == 0);

      if (hsn !== (c >= 29) || fsn !== (r >= VSYNC)) syncBad++;
      if (hblank !== !inH || vblank !== !inV || de !== (inH && inV)) blankBad++;
      if (col !== 9'(c) || row !== 9'(r) || frame_sof !== (i == 0)) posBad++;
      if (fetch !== fE || byte_idx !== 5'(k) || preload !== (fE && k == 0)) fetchBad++;
      if (cell_line !== 4'(clE) || cell_row !== 5'(crE) || rowclear !== rcE) cellBad++;

      if (frame_sof === 1'b1) sofCnt++;
      if (hsn === 1'b0) hsnLow++;
      if (fsn === 1'b0) fsnLow++;
      if (rowclear === 1'b1) clrCnt++;
      if (int'(cell_row) > maxRow) maxRow = int'(cell_row);
      if (de === 1'b1) begin
        deCnt++;
        if (firstDe < 0) firstDe = i;
      end
      if (fetch === 1'b1) begin
        fetchCnt++;
        if (firstFetch < 0) begin
          firstFetch = i;
          firstPre   = preload;
        end
      end

      if (i == 20 * HT + 100) begin
        format    = nf;
        char_rows = nc;
      end
      if (i == (vt - 2) * HT + 100) width_mode = nw;
    end
    chk({nm, "_sync_bad"}, syncBad, 0);
    chk({nm, "_blank_bad"}, blankBad, 0);
    chk({nm, "_pos_bad"}, posBad, 0);
    chk({nm, "_fetch_bad"}, fetchBad, 0);
    chk({nm, "_cell_bad"}, cellBad, 0);
    chk({nm, "_sof_count"}, sofCnt, 1);
    chk({nm, "_hsn_low"}, hsnLow, 29 * vt);
    chk({nm, "_fsn_low"}, fsnLow, VSYNC * HT);
    chk({nm, "_de_count"}, deCnt, 256 * PH);
    chk({nm, "_fetch_count"}, fetchCnt, expFetch);
    chk({nm, "_first_fetch"}, firstFetch, expFirstFetch);
    chk({nm, "_first_preload"}, firstPre, 1);
    chk({nm, "_first_de"}, firstDe, expFirstDe);
    chk({nm, "_rowclear_count"}, clrCnt, expClr);
    chk({nm, "_max_cell_row"}, maxRow, expMaxRow);
  endtask

  initial begin
    reset_n    = 1'b1;
    format     = 1'b0;
    width_mode = 2'b00;
    char_rows  = 4'd0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hsn", hsn, 1);
    chk("rst_fsn", fsn, 1);
    chk("rst_hblank", hblank, 1);
    chk("rst_vblank", vblank, 1);
    chk("rst_de", de, 0);
    chk("rst_sof", frame_sof, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    reset_n = 1'b1;

    // NTSC 12-line cells, 32 B/line; switch to PAL / 1-line cells at row 20.
    runFrame("f1_ntsc", VT_N, PY_N, 12, 8, 1'b1, 4'd1, 2'b10,
             1152, 1953, 1961, 3, 2);
    // PAL 1-line cells saturate cell_row; 8 B/line.
    runFrame("f2_pal", VT_P, PY_P, 1, 32, 1'b0, 4'd3, 2'b01,
             288, 3785, 3793, 36, 31);
    // NTSC 3-line cells, 16 B/line.
    runFrame("f3_ntsc", VT_N, PY_N, 3, 16, 1'b0, 4'd3, 2'b01,
             576, 1953, 1961, 12, 11);

    repeat (20 * HT + 201) @(negedge clk);
    chk("pre_rst_col", col, 200);
    chk("pre_rst_row", row, 20);
    chk("pre_rst_de", de, 1);
    chk("pre_rst_cell_line", cell_line, 1);
    chk("pre_rst_cell_row", cell_row, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_col", col, 0);
    chk("async_rst_row", row, 0);
    chk("async_rst_de", de, 0);
    chk("async_rst_hblank", hblank, 1);
    chk("async_rst_vblank", vblank, 1);
    chk("async_rst_cell_line", cell_line, 0);
    chk("async_rst_cell_row", cell_row, 0);
    format    = 1'b1;
    char_rows = 4'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_sof", frame_sof, 1);
    chk("rel_col", col, 0);
    chk("rel_row", row, 0);
    chk("rel_hsn", hsn, 0);
    chk("rel_fsn", fsn, 0);
    @(negedge clk);
    chk("rel_sof_off", frame_sof, 0);
    chk("rel_col1", col, 1);
    repeat (4 * HT + 129 - 1) @(negedge clk);
    chk("rel_pal_no_de_ntsc_row", de, 0);
    chk("rel_pal_vblank_ntsc_row", vblank, 1);
    repeat (4 * HT) @(negedge clk);
    chk("rel_pal_first_de", de, 1);
    chk("rel_pal_first_de_row", row, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
